// File: rtl/sorted_result_serializer_if.sv
// Handshake bundle between the sorting network, the serializer and its consumer.
// SERIALIZER_TOPK_EN adds the in_count field (elements to emit per load).
interface sorted_result_serializer_if #(
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 4,
    parameter int NUM_ELEMENTS  = 16
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [NUM_ELEMENTS*NETWORK_WIDTH-1:0] in_values;
    logic [NUM_ELEMENTS*INDEX_WIDTH-1:0]   in_indices;
    logic                                  in_descending;
`ifdef SERIALIZER_TOPK_EN
    logic [INDEX_WIDTH:0]                  in_count;
`endif
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NETWORK_WIDTH-1:0]              out_value;
    logic [INDEX_WIDTH-1:0]                out_index;
    logic                                  out_last;
    logic                                  busy;

    modport master (
`ifdef SERIALIZER_TOPK_EN
        output in_count,
`endif
        output in_valid,
        output in_values,
        output in_indices,
        output in_descending,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_index,
        input  out_last,
        input  busy
    );

    modport slave (
`ifdef SERIALIZER_TOPK_EN
        input  in_count,
`endif
        input  in_valid,
        input  in_values,
        input  in_indices,
        input  in_descending,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_index,
        output out_last,
        output busy
    );
endinterface

// File: rtl/sorted_result_serializer.sv
// Captures one sorted network result and streams it out one element per beat.
// SERIALIZER_TOPK_EN limits each load to the first in_count elements.
module sorted_result_serializer #(
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 4,
    parameter int NUM_ELEMENTS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    sorted_result_serializer_if.slave bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH:0]   REM_FULL = (INDEX_WIDTH+1)'(NUM_ELEMENTS);
    localparam logic [INDEX_WIDTH:0]   REM_ONE  = (INDEX_WIDTH+1)'(1);
    localparam logic [INDEX_WIDTH-1:0] PTR_MAX  = INDEX_WIDTH'(NUM_ELEMENTS-1);
    localparam logic [INDEX_WIDTH-1:0] PTR_ONE  = INDEX_WIDTH'(1);

    state_t state_q;
    state_t state_d;

    logic [NETWORK_WIDTH-1:0] val_q [NUM_ELEMENTS];
    logic [INDEX_WIDTH-1:0]   idx_q [NUM_ELEMENTS];
    logic                     desc_q;
    logic [INDEX_WIDTH-1:0]   ptr_q;
    logic [INDEX_WIDTH:0]     rem_q;

    logic                     load;
    logic                     start;
    logic                     xfer;
    logic                     last;
    logic [INDEX_WIDTH:0]     load_cnt;

    // Number of elements a load will emit; zero means accept-and-drop.
    always_comb begin
        load_cnt = REM_FULL;
`ifdef SERIALIZER_TOPK_EN
        if (bus.in_count < REM_FULL) begin
            load_cnt = bus.in_count;
        end
`endif
    end

    assign load  = (state_q == IDLE) && bus.in_valid;
    assign start = load && (load_cnt != '0);
    assign xfer  = (state_q == STREAM) && bus.out_ready;
    assign last  = (rem_q == REM_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            (state_q == STREAM): begin
                if (xfer && last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == STREAM);
        bus.busy      = (state_q == STREAM);
        bus.out_value = '0;
        bus.out_index = '0;
        bus.out_last  = 1'b0;
        if (state_q == STREAM) begin
            bus.out_value = val_q[ptr_q];
            bus.out_index = idx_q[ptr_q];
            bus.out_last  = last;
        end
    end

    // Lane buffer, direction, read pointer and beats-left counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                val_q[k] <= '0;
                idx_q[k] <= '0;
            end
            desc_q <= 1'b0;
            ptr_q  <= '0;
            rem_q  <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                val_q[k] <= bus.in_values[k*NETWORK_WIDTH +: NETWORK_WIDTH];
                idx_q[k] <= bus.in_indices[k*INDEX_WIDTH +: INDEX_WIDTH];
            end
            desc_q <= bus.in_descending;
            ptr_q  <= bus.in_descending ? PTR_MAX : '0;
            rem_q  <= load_cnt;
        end else if (xfer) begin
            rem_q <= rem_q - REM_ONE;
            // Pointer parks on the final lane rather than wrapping.
            if (!last) begin
                ptr_q <= desc_q ? (ptr_q - PTR_ONE) : (ptr_q + PTR_ONE);
            end
        end
    end
endmodule

// File: tb/tb_sorted_result_serializer.sv
// Randomized bench for sorted_result_serializer against a queue-based model.
// Build with +define+SERIALIZER_TOPK_EN to also cover the in_count feature.
module tb_sorted_result_serializer;
    localparam int NW = 16;
    localparam int IW = 4;
    localparam int N  = 16;
`ifdef SERIALIZER_TOPK_EN
    localparam bit TOPK = 1'b1;
`else
    localparam bit TOPK = 1'b0;
`endif

    typedef struct {
        logic [NW-1:0] v;
        logic [IW-1:0] i;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sorted_result_serializer_if #(
        .NETWORK_WIDTH(NW),
        .INDEX_WIDTH  (IW),
        .NUM_ELEMENTS (N)
    ) bus ();

    sorted_result_serializer #(
        .NETWORK_WIDTH(NW),
        .INDEX_WIDTH  (IW),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    int            beats = 0;
    int            loads = 0;
    beat_t         exp_q[$];
    logic [NW-1:0] vals[N];
    logic [IW-1:0] idxs[N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected beats of a load: lanes walked in the requested direction.
    task automatic load_model(input bit desc, input int cnt);
        int n;
        n = N;
        if (TOPK) n = (cnt > N) ? N : cnt;
        loads++;
        for (int k = 0; k < n; k++) begin
            int lane;
            lane = desc ? (N - 1 - k) : k;
            exp_q.push_back('{v: vals[lane], i: idxs[lane]});
        end
    endtask

    task automatic check_outs();
        if (exp_q.size() > 0) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_value", bus.out_value, exp_q[0].v);
            chk("out_index", bus.out_index, exp_q[0].i);
            chk("out_last",  bus.out_last, exp_q.size() == 1);
            chk("in_ready",  bus.in_ready, 0);
            chk("busy",      bus.busy, 1);
        end else begin
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_value", bus.out_value, 0);
            chk("idle_index", bus.out_index, 0);
            chk("idle_last",  bus.out_last, 0);
            chk("idle_ready", bus.in_ready, 1);
            chk("idle_busy",  bus.busy, 0);
        end
    endtask

    // One clock: check what the DUT shows now, then drive the next inputs.
    task automatic step(input bit iv, input bit desc, input bit ordy,
                        input int cnt);
        @(negedge clk);
        check_outs();
        bus.in_valid      = iv;
        bus.in_descending = desc;
        bus.out_ready     = ordy;
        for (int k = 0; k < N; k++) begin
            bus.in_values[k*NW +: NW]  = vals[k];
            bus.in_indices[k*IW +: IW] = idxs[k];
        end
`ifdef SERIALIZER_TOPK_EN
        bus.in_count = cnt[IW:0];
`endif
        if (exp_q.size() > 0) begin
            if (ordy) begin
                void'(exp_q.pop_front());
                beats++;
            end
        end else if (iv) begin
            load_model(desc, cnt);
        end
    endtask

    task automatic drain(input string tag, input bit random_ready);
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
            step(1'b0, 1'b0, random_ready ? ($urandom_range(0, 2) != 0) : 1'b1, N);
        end
        chk(tag, exp_q.size(), 0);
        step(1'b0, 1'b0, 1'b1, N);
    endtask

    task automatic ramp_vector();
        for (int k = 0; k < N; k++) begin
            vals[k] = NW'(10 * k);
            idxs[k] = IW'(k);
        end
    endtask

    task automatic random_vector();
        int q[$];
        int span;
        span = ($urandom_range(0, 1) == 0) ? 7 : 65535;
        for (int k = 0; k < N; k++) q.push_back($urandom_range(0, span));
        q.sort();
        for (int k = 0; k < N; k++) begin
            vals[k] = NW'(q[k]);
            idxs[k] = IW'($urandom_range(0, N - 1));
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_descending = 1'b0;
        bus.out_ready     = 1'b0;
        bus.in_values     = '0;
        bus.in_indices    = '0;
`ifdef SERIALIZER_TOPK_EN
        bus.in_count      = '0;
`endif
        ramp_vector();
        repeat (2) @(negedge clk);
        check_outs();
        rst = 1'b0;

        // Ascending then descending readout of the ramp vector.
        beats = 0;
        step(1'b1, 1'b0, 1'b1, N);
        drain("asc_drain", 1'b0);
        chk("asc_beats", beats, 16);
        beats = 0;
        step(1'b1, 1'b1, 1'b1, N);
        drain("desc_drain", 1'b0);
        chk("desc_beats", beats, 16);

        // Backpressure: out_ready pattern 1,0,0 repeating.
        beats = 0;
        step(1'b1, 1'b0, 1'b1, N);
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
            step(1'b0, 1'b0, (t % 3) == 0, N);
        end
        drain("bp_drain", 1'b0);
        chk("bp_beats", beats, 16);

        // in_valid held high: second vector accepted one cycle after last.
        beats = 0;
        loads = 0;
        for (int t = 0; t < 34; t++) begin
            if (t == 5) begin
                for (int k = 0; k < N; k++) vals[k] = NW'(1000 + k);
            end
            step(1'b1, 1'b0, 1'b1, N);
        end
        drain("b2b_drain", 1'b0);
        chk("b2b_loads", loads, 2);
        chk("b2b_beats", beats, 32);

        // Reset asserted mid-stream after five transfers.
        ramp_vector();
        step(1'b1, 1'b0, 1'b1, N);
        repeat (5) step(1'b0, 1'b0, 1'b1, N);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_value", bus.out_value, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b1, N);

`ifdef SERIALIZER_TOPK_EN
        // Top-k: three largest, then a zero-count load.
        beats = 0;
        step(1'b1, 1'b1, 1'b1, 3);
        drain("topk_drain", 1'b0);
        chk("topk_beats", beats, 3);
        step(1'b1, 1'b0, 1'b1, 0);
        repeat (3) step(1'b0, 1'b0, 1'b1, N);
`endif

        // Random traffic with random stalls, directions and counts.
        for (int t = 0; t < 1500; t++) begin
            if (exp_q.size() == 0) random_vector();
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2 * N - 1));
        end
        drain("rand_drain", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
